station_material_ctrl: RTL and testbench
========================================

// Module: station_material_ctrl
// PURPOSE
//  Parametrised station/washer controller, successor to the single-station material FSM.
//  - Debounces the KY-032 station trigger (active low).
//  - Averages XADC temperature samples and classifies the station as HOT, COLD or NONE.
//  - Drives the washer electromagnet: pick up at HOT, drop at COLD.
//  - Pulses correct_station to the seven-segment system.
// PARAMETERS
//  ADC_W       12    XADC sample width
//  AVG_LOG2    2     log2 of samples averaged per station (2 -> 4 samples)
//  HOT_TH      12'hA00  avg >= HOT_TH -> HOT
//  COLD_TH     12'h600  avg <= COLD_TH -> COLD (HOT_TH > COLD_TH required)
//  DEB_CYC     16    cycles trigger must hold low to qualify
//  SETTLE_CYC  100   cycles between qualify and first sample (0.1 s at 1 kHz ACLK)
//  HOLD_CYC    200   cycles magnet state is held before re-arm
//  TMO_CYC     1000  max cycles waiting for all samples
//  CNT_W       8     width of washer/station counters
// PORTS
//  CLK             in   1        ACLK; all logic on rising edge
//  RST_N           in   1        asynchronous, active-low reset
//  trigger         in   1        station sensor, active low, asynchronous to CLK
//  digitalTemp     in   ADC_W    XADC result
//  ready           in   1        XADC result valid, one-cycle strobe
//  enableIR        out  1        IR sensor power
//  correctStation  out  1        1-cycle pulse when a pickup or drop is executed
//  stationClass    out  2        0 NONE, 1 HOT, 2 COLD; held until next classify
//  controlSignal   out  1        electromagnet drive
//  carrying        out  1        washer held
//  stationCount    out  CNT_W    stations classified, wraps
//  deliveredCount  out  CNT_W    washers dropped, saturates at all-ones
//  sampleErr       out  1        sticky; set on sample timeout
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - enableIR=1; all other outputs 0; FSM in IDLE.
//   - Magnet drops immediately on reset, including mid-carry.
//  Input synchronisation: trigger passes a 2-FF synchroniser; all decisions use trig_s.
//  FSM states and transitions:
//   - IDLE:
//     - trig_s==0 -> DEBOUNCE, counter cleared.
//   - DEBOUNCE:
//     - trig_s==1 before DEB_CYC -> IDLE.
//     - Else -> SETTLE; enableIR=0.
//   - SETTLE: count SETTLE_CYC -> SAMPLE; accumulator cleared.
//   - SAMPLE:
//     - Each ready strobe adds digitalTemp to an (ADC_W+AVG_LOG2)-bit accumulator.
//     - After 2^AVG_LOG2 strobes -> CLASSIFY.
//     - TMO_CYC elapsed first -> sampleErr=1, class NONE, go to HOLD.
//   - CLASSIFY (1 cycle):
//     - avg = acc >> AVG_LOG2, truncating.
//     - Update stationClass; stationCount++.
//     - HOT & !carrying -> ACTUATE (pickup).
//     - COLD & carrying -> ACTUATE (drop).
//     - Otherwise -> HOLD with no actuation.
//   - ACTUATE (1 cycle):
//     - Pickup: controlSignal=1, carrying=1.
//     - Drop: controlSignal=0, carrying=0, deliveredCount++.
//     - correctStation=1 this cycle only, then -> HOLD.
//   - HOLD: count HOLD_CYC, then -> REARM.
//   - REARM:
//     - Wait trig_s==1 (station left); then enableIR=1 -> IDLE.
//     - Prevents double-count of the same station.
//  Latency: trigger low -> first sample window opens after 2+DEB_CYC+SETTLE_CYC cycles.
//  Boundary conditions:
//   - Trigger glitches shorter than DEB_CYC are ignored.
//   - Trigger released after DEBOUNCE has no effect until REARM.
//   - ready during non-SAMPLE states is ignored.
//   - Avg exactly HOT_TH -> HOT; exactly COLD_TH -> COLD.
//   - HOT while carrying, or COLD while empty -> class updated, no pulse.
//   - stationCount wraps to 0; deliveredCount saturates.
//   - Magnet stays energised through HOLD/REARM/IDLE while carrying.
// STRUCTURE
//  Shared package station_pkg: state encoding, class encoding (NONE/HOT/COLD).
//  Sub-module temp_averager: accumulator, sample counter, timeout counter.
//   - Interface: start, ready/data in; done, timeout, avg out.
//  FSM, counters and debounce stay in the top.
// TESTING
//  1. Reset, then trigger low 20 cyc; 4 samples of 12'hB00 -> stationClass=1, controlSignal=1,
//     carrying=1, one correctStation pulse.
//  2. Continue from 1: next station, samples 12'h400 -> stationClass=2, controlSignal=0,
//     deliveredCount=1, one pulse.
//  3. Trigger low 10 cyc (< DEB_CYC) -> FSM stays IDLE, enableIR=1, stationCount unchanged.
//  4. Station qualified, no ready strobes for 1000 cyc -> sampleErr=1, stationClass=0, no pulse.
//  5. Samples 12'hA00 x4 while carrying -> stationClass=1, no pulse, magnet still on.
//  6. Assert RST_N=0 during HOLD while carrying -> controlSignal=0 within the same cycle,
//     all counters 0.

Source files
------------

// File: rtl/station_pkg.sv
// Shared encodings for the station/washer controller: FSM states, station
// classes and the threshold classification helper.
package station_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DEBOUNCE = 3'd1,
      S_SETTLE   = 3'd2,
      S_SAMPLE   = 3'd3,
      S_CLASSIFY = 3'd4,
      S_ACTUATE  = 3'd5,
      S_HOLD     = 3'd6,
      S_REARM    = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      CLS_NONE = 2'd0,
      CLS_HOT  = 2'd1,
      CLS_COLD = 2'd2
   } class_t;

   // Both thresholds are inclusive; HOT wins if the ranges were ever to overlap.
   function automatic class_t classify_avg(input logic [31:0] avg,
                                           input logic [31:0] hot_th,
                                           input logic [31:0] cold_th);
      if (avg >= hot_th)
         return CLS_HOT;
      else if (avg <= cold_th)
         return CLS_COLD;
      else
         return CLS_NONE;
   endfunction

endpackage

// File: rtl/temp_averager.sv
// Collects 2^AVG_LOG2 XADC samples after a start pulse and reports their
// truncated mean, or a timeout if the samples do not arrive in time.
module temp_averager #(
   parameter int unsigned ADC_W    = 12,
   parameter int unsigned AVG_LOG2 = 2,
   parameter int unsigned TMO_CYC  = 1000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_ready,
   input  logic [ADC_W-1:0] i_data,
   output logic             o_done,
   output logic             o_timeout,
   output logic [ADC_W-1:0] o_avg
);

   localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
   localparam int unsigned NSAMP = 2 ** AVG_LOG2;
   localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

   logic                r_active;
   logic [AVG_LOG2:0]   r_n;
   logic [TMO_W-1:0]    r_tmo;
   logic                r_done;
   logic                r_timeout;
   logic [ACC_W-1:0]    r_acc;
   logic                w_last;
   logic                w_tmo_hit;

   assign w_last    = i_ready && (r_n == (AVG_LOG2 + 1)'(NSAMP - 1));
   assign w_tmo_hit = (r_tmo == TMO_W'(TMO_CYC - 1));

   // Sampling window control: sample count, timeout count and result strobes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_active  <= 1'b0;
         r_n       <= '0;
         r_tmo     <= '0;
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_timeout <= 1'b0;
         if (i_start) begin
            r_active <= 1'b1;
            r_n      <= '0;
            r_tmo    <= '0;
         end else if (r_active) begin
            r_tmo <= r_tmo + 1'b1;
            if (i_ready)
               r_n <= r_n + 1'b1;
            if (w_last) begin
               r_active <= 1'b0;
               r_done   <= 1'b1;
            end else if (w_tmo_hit) begin
               r_active  <= 1'b0;
               r_timeout <= 1'b1;
            end
         end
      end
   end

   // Accumulator is pure data: cleared by start, so it needs no reset.
   always_ff @(posedge i_clk) begin
      if (i_start)
         r_acc <= '0;
      else if (r_active && i_ready)
         r_acc <= r_acc + ACC_W'(i_data);
   end

   assign o_done    = r_done;
   assign o_timeout = r_timeout;
   assign o_avg     = ADC_W'(r_acc >> AVG_LOG2);

endmodule

// File: rtl/station_material_ctrl.sv
// Station/washer controller: debounces the station trigger, averages the
// station temperature, classifies it and picks up / drops the washer.
module station_material_ctrl
   import station_pkg::*;
#(
   parameter int unsigned ADC_W      = 12,
   parameter int unsigned AVG_LOG2   = 2,
   parameter int unsigned HOT_TH     = 'hA00,
   parameter int unsigned COLD_TH    = 'h600,
   parameter int unsigned DEB_CYC    = 16,
   parameter int unsigned SETTLE_CYC = 100,
   parameter int unsigned HOLD_CYC   = 200,
   parameter int unsigned TMO_CYC    = 1000,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             trigger,
   input  logic [ADC_W-1:0] digitalTemp,
   input  logic             ready,
   output logic             enableIR,
   output logic             correctStation,
   output logic [1:0]       stationClass,
   output logic             controlSignal,
   output logic             carrying,
   output logic [CNT_W-1:0] stationCount,
   output logic [CNT_W-1:0] deliveredCount,
   output logic             sampleErr
);

   localparam int unsigned CYC_MAX0 = (DEB_CYC > SETTLE_CYC) ? DEB_CYC : SETTLE_CYC;
   localparam int unsigned CYC_MAX  = (CYC_MAX0 > HOLD_CYC) ? CYC_MAX0 : HOLD_CYC;
   localparam int unsigned CYC_W    = $clog2(CYC_MAX + 1);

   logic             r_trig_meta;
   logic             r_trig_s;
   state_t           r_state;
   state_t           w_next;
   logic [CYC_W-1:0] r_cnt;
   logic             w_cnt_clr;
   logic             w_start;
   logic             r_enable_ir;
   class_t           r_class;
   class_t           w_cls;
   logic             r_ctrl;
   logic             r_carry;
   logic [CNT_W-1:0] r_stn_cnt;
   logic [CNT_W-1:0] r_dlv_cnt;
   logic             r_err;
   logic             w_done;
   logic             w_timeout;
   logic [ADC_W-1:0] w_avg;

   temp_averager #(
      .ADC_W    (ADC_W),
      .AVG_LOG2 (AVG_LOG2),
      .TMO_CYC  (TMO_CYC)
   ) u_avg (
      .i_clk     (CLK),
      .i_rst_n   (RST_N),
      .i_start   (w_start),
      .i_ready   (ready),
      .i_data    (digitalTemp),
      .o_done    (w_done),
      .o_timeout (w_timeout),
      .o_avg     (w_avg)
   );

   assign w_cls = classify_avg(32'(w_avg), HOT_TH, COLD_TH);

   // Two-flop synchroniser; idles high because the trigger is active low.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_trig_meta <= 1'b1;
         r_trig_s    <= 1'b1;
      end else begin
         r_trig_meta <= trigger;
         r_trig_s    <= r_trig_meta;
      end
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic, shared cycle-counter clear and averager start.
   always_comb begin
      w_next    = r_state;
      w_cnt_clr = 1'b0;
      w_start   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_trig_s) begin
               w_next    = S_DEBOUNCE;
               w_cnt_clr = 1'b1;
            end
         end
         S_DEBOUNCE: begin
            if (r_trig_s) begin
               w_next = S_IDLE;
            end else if (r_cnt == CYC_W'(DEB_CYC - 1)) begin
               w_next    = S_SETTLE;
               w_cnt_clr = 1'b1;
            end
         end
         S_SETTLE: begin
            if (r_cnt == CYC_W'(SETTLE_CYC - 1)) begin
               w_next    = S_SAMPLE;
               w_cnt_clr = 1'b1;
               w_start   = 1'b1;
            end
         end
         S_SAMPLE: begin
            if (w_done) begin
               w_next = S_CLASSIFY;
            end else if (w_timeout) begin
               w_next    = S_HOLD;
               w_cnt_clr = 1'b1;
            end
         end
         S_CLASSIFY: begin
            w_cnt_clr = 1'b1;
            if ((w_cls == CLS_HOT && !r_carry) || (w_cls == CLS_COLD && r_carry))
               w_next = S_ACTUATE;
            else
               w_next = S_HOLD;
         end
         S_ACTUATE: begin
            w_next    = S_HOLD;
            w_cnt_clr = 1'b1;
         end
         S_HOLD: begin
            if (r_cnt == CYC_W'(HOLD_CYC - 1))
               w_next = S_REARM;
         end
         S_REARM: begin
            if (r_trig_s)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Shared cycle counter for debounce, settle and hold intervals.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         r_cnt <= '0;
      else if (w_cnt_clr)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   // Station outputs: IR power, class, magnet, counters and sticky error.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_enable_ir <= 1'b1;
         r_class     <= CLS_NONE;
         r_ctrl      <= 1'b0;
         r_carry     <= 1'b0;
         r_stn_cnt   <= '0;
         r_dlv_cnt   <= '0;
         r_err       <= 1'b0;
      end else begin
         if (r_state == S_DEBOUNCE && w_next == S_SETTLE)
            r_enable_ir <= 1'b0;
         if (r_state == S_REARM && w_next == S_IDLE)
            r_enable_ir <= 1'b1;
         if (r_state == S_SAMPLE && !w_done && w_timeout) begin
            r_err   <= 1'b1;
            r_class <= CLS_NONE;
         end
         if (r_state == S_CLASSIFY) begin
            r_class   <= w_cls;
            r_stn_cnt <= r_stn_cnt + 1'b1;
         end
         // ACTUATE is only entered for a pickup when empty or a drop when carrying.
         if (r_state == S_ACTUATE) begin
            if (r_carry) begin
               r_ctrl  <= 1'b0;
               r_carry <= 1'b0;
               if (r_dlv_cnt != '1)
                  r_dlv_cnt <= r_dlv_cnt + 1'b1;
            end else begin
               r_ctrl  <= 1'b1;
               r_carry <= 1'b1;
            end
         end
      end
   end

   assign enableIR       = r_enable_ir;
   assign correctStation = (r_state == S_ACTUATE);
   assign stationClass   = r_class;
   assign controlSignal  = r_ctrl;
   assign carrying       = r_carry;
   assign stationCount   = r_stn_cnt;
   assign deliveredCount = r_dlv_cnt;
   assign sampleErr      = r_err;

endmodule

// File: tb/tb_station_material_ctrl.sv
// Bench for station_material_ctrl: directed station scenarios plus random
// station temperatures, checked against a station-level behavioural model.
// Counters are narrowed to 3 bits so wrap and saturation are reachable.
module tb_station_material_ctrl;

   localparam int CW = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          trigger = 1'b1;
   logic [11:0]   digitalTemp = '0;
   logic          ready = 1'b0;
   logic          enableIR;
   logic          correctStation;
   logic [1:0]    stationClass;
   logic          controlSignal;
   logic          carrying;
   logic [CW-1:0] stationCount;
   logic [CW-1:0] deliveredCount;
   logic          sampleErr;

   station_material_ctrl #(.CNT_W(CW)) dut (
      .CLK            (CLK),
      .RST_N          (RST_N),
      .trigger        (trigger),
      .digitalTemp    (digitalTemp),
      .ready          (ready),
      .enableIR       (enableIR),
      .correctStation (correctStation),
      .stationClass   (stationClass),
      .controlSignal  (controlSignal),
      .carrying       (carrying),
      .stationCount   (stationCount),
      .deliveredCount (deliveredCount),
      .sampleErr      (sampleErr)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   int pulses = 0;

   // Model state: what the station sequence so far implies.
   int m_class = 0;
   int m_carry = 0;
   int m_scnt  = 0;
   int m_dcnt  = 0;
   int m_err   = 0;
   int m_pulses = 0;

   always @(negedge CLK) begin
      if (correctStation === 1'b1)
         pulses = pulses + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      tests = tests + 1;
      assert (obs === exp) else begin
         fails = fails + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".class"},   int'(stationClass),   m_class);
      check({tag, ".ctrl"},    int'(controlSignal),  m_carry);
      check({tag, ".carry"},   int'(carrying),       m_carry);
      check({tag, ".scnt"},    int'(stationCount),   m_scnt);
      check({tag, ".dcnt"},    int'(deliveredCount), m_dcnt);
      check({tag, ".err"},     int'(sampleErr),      m_err);
      check({tag, ".pulses"},  pulses,               m_pulses);
   endtask

   // Station rule: mean of four samples (truncated), inclusive thresholds,
   // pick up on HOT when empty, drop on COLD when carrying.
   task automatic model_station(input logic [47:0] smp);
      int sum;
      int avg;
      int cls;
      sum = 0;
      for (int i = 0; i < 4; i++)
         sum = sum + int'(smp[12*i +: 12]);
      avg = sum / 4;
      if (avg >= 'hA00)      cls = 1;
      else if (avg <= 'h600) cls = 2;
      else                   cls = 0;
      m_class = cls;
      m_scnt  = (m_scnt + 1) % (CMAX + 1);
      if (cls == 1 && m_carry == 0) begin
         m_carry  = 1;
         m_pulses = m_pulses + 1;
      end else if (cls == 2 && m_carry == 1) begin
         m_carry  = 0;
         m_pulses = m_pulses + 1;
         if (m_dcnt < CMAX) m_dcnt = m_dcnt + 1;
      end
   endtask

   task automatic strobe(input logic [11:0] v);
      ready = 1'b1;
      digitalTemp = v;
      @(negedge CLK);
      ready = 1'b0;
   endtask

   // Trigger held 20 cycles; a stray strobe lands during settle; the four
   // real samples start 130 cycles after the trigger fell.
   task automatic station_front(input string tag);
      trigger = 1'b0;
      repeat (20) @(negedge CLK);
      trigger = 1'b1;
      repeat (40) @(negedge CLK);
      strobe(12'hFFF);
      repeat (69) @(negedge CLK);
      check({tag, ".irOff"}, int'(enableIR), 0);
   endtask

   task automatic run_station(input string tag, input logic [47:0] smp, input bit rearm);
      station_front(tag);
      for (int i = 0; i < 4; i++) begin
         strobe(smp[12*i +: 12]);
         repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
      repeat (10) @(negedge CLK);
      model_station(smp);
      check_all(tag);
      if (rearm) begin
         repeat (205) @(negedge CLK);
         check({tag, ".irOn"}, int'(enableIR), 1);
      end
   endtask

   function automatic logic [47:0] rand_smp(input int lo, input int hi);
      logic [47:0] s;
      for (int i = 0; i < 4; i++)
         s[12*i +: 12] = 12'($urandom_range(hi, lo));
      return s;
   endfunction

   initial begin
      logic [47:0] s;
      int pick;

      // Reset state
      repeat (3) @(negedge CLK);
      check_all("reset");
      check("reset.ir", int'(enableIR), 1);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);

      // 1: hot station picks up the washer
      run_station("t1_hot", {4{12'hB00}}, 1'b1);
      // 2: cold station drops it
      run_station("t2_cold", {4{12'h400}}, 1'b1);

      // 3: glitch shorter than the debounce window is ignored
      trigger = 1'b0;
      repeat (10) @(negedge CLK);
      trigger = 1'b1;
      repeat (130) @(negedge CLK);
      for (int i = 0; i < 4; i++) strobe(12'hB00);
      repeat (20) @(negedge CLK);
      check("t3_glitch.ir", int'(enableIR), 1);
      check_all("t3_glitch");

      // 4: no samples arrive -> sticky error, class NONE, no pulse
      station_front("t4_tmo");
      repeat (1030) @(negedge CLK);
      m_err = 1;
      m_class = 0;
      check_all("t4_tmo");
      repeat (205) @(negedge CLK);
      check("t4_tmo.irOn", int'(enableIR), 1);

      // 5: pick up again, then exactly HOT_TH while carrying -> no pulse
      run_station("t5_pick", {4{12'hB00}}, 1'b1);
      run_station("t5_hotTh", {4{12'hA00}}, 1'b1);
      // exactly COLD_TH while carrying -> drop
      run_station("t5_coldTh", {4{12'h600}}, 1'b1);
      // COLD while empty -> class only
      run_station("t5_coldEmpty", {4{12'h100}}, 1'b1);

      // Random stations mixing near-threshold and wide ranges
      for (int k = 0; k < 10; k++) begin
         pick = int'($urandom_range(3, 0));
         case (pick)
            0: s = rand_smp('h500, 'h700);
            1: s = rand_smp('h980, 'hA80);
            2: s = rand_smp('h000, 'hFFF);
            default: s = rand_smp('hA00, 'hFFF);
         endcase
         run_station("rand", s, 1'b1);
      end

      // Pickup/drop pairs drive the delivered counter into saturation
      for (int k = 0; k < 8; k++) begin
         run_station("satPick", rand_smp('hA00, 'hFFF), 1'b1);
         run_station("satDrop", rand_smp('h000, 'h600), 1'b1);
      end
      check("sat.dcnt", int'(deliveredCount), CMAX);

      // 6: reset while carrying in HOLD drops the magnet immediately
      run_station("t6_pick", {4{12'hC00}}, 1'b0);
      repeat (20) @(negedge CLK);
      check("t6.carryBefore", int'(carrying), 1);
      RST_N = 1'b0;
      #1;
      m_class = 0; m_carry = 0; m_scnt = 0; m_dcnt = 0; m_err = 0;
      m_pulses = pulses;
      check_all("t6_reset");
      check("t6_reset.ir", int'(enableIR), 1);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
